// File: rtl/ram_responder.sv
// Word-addressable backing store for the cache's RAM-side burst protocol (line fill / write-back).
// Optional `RAM_STATS_EN adds per-direction completed-burst counters.
module ram_responder #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned WORDS      = 32,
    parameter int unsigned OFFSET     = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_read,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_write,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  init_busy,
    output logic                  burst_done,
    output logic                  err_proto,
    output logic                  err_burst,
    input  logic                  err_clear
`ifdef RAM_STATS_EN
    ,
    output logic [15:0]           rd_bursts,
    output logic [15:0]           wr_bursts
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = OFFSET + 1;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        RBURST,
        WBURST
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   expected;
    logic [CNT_W-1:0]        count;
    logic                    burst_bad;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    beat_c;
    logic                    same_dir_c;
    logic                    set_proto_c;
    logic                    set_burst_c;
    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_waddr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;

    assign init_busy = (state == CLEAR);

    // The clear sweep owns the write port; otherwise any write beat (with or without read) lands.
    assign mem_we_c    = !rst && ((state == CLEAR) || ram_write);
    assign mem_waddr_c = (state == CLEAR) ? ptr : ram_addr;
    assign mem_wdata_c = (state == CLEAR) ? '0 : ram_data_in;

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Protocol / framing error detection for the current edge.
    always_comb begin
        beat_c      = ram_read || ram_write;
        same_dir_c  = ((state == RBURST) && !ram_write) || ((state == WBURST) && ram_write);
        set_proto_c = 1'b0;
        set_burst_c = 1'b0;
        case (state)
            CLEAR: begin
                set_proto_c = beat_c;
            end
            IDLE: begin
                if (beat_c) begin
                    set_proto_c = ram_read && ram_write;
                    set_burst_c = (ram_addr[OFFSET-1:0] != '0);
                end
            end
            RBURST, WBURST: begin
                if (!beat_c) begin
                    set_burst_c = (count != CNT_W'(WORDS));
                end else if (!same_dir_c) begin
                    set_proto_c = 1'b1;
                end else begin
                    set_proto_c = ram_read && ram_write;
                    set_burst_c = (ram_addr != expected) || (count >= CNT_W'(WORDS));
                end
            end
            default: begin
                set_proto_c = 1'b0;
                set_burst_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            ptr          <= '0;
            expected     <= '0;
            count        <= '0;
            burst_bad    <= 1'b0;
            ram_data_out <= '0;
            burst_done   <= 1'b0;
            err_proto    <= 1'b0;
            err_burst    <= 1'b0;
`ifdef RAM_STATS_EN
            rd_bursts    <= '0;
            wr_bursts    <= '0;
`endif
        end else begin
            burst_done <= 1'b0;
            // A fresh error on the same edge as err_clear keeps the flag set.
            err_proto  <= (err_proto && !err_clear) || set_proto_c;
            err_burst  <= (err_burst && !err_clear) || set_burst_c;

            if ((state != CLEAR) && ram_read && !ram_write) begin
                ram_data_out <= mem[ram_addr];
            end

            case (state)
                CLEAR: begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (ptr == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (beat_c) begin
                        state     <= ram_write ? WBURST : RBURST;
                        count     <= CNT_W'(1);
                        expected  <= ram_addr + ADDR_WIDTH'(1);
                        burst_bad <= set_proto_c || set_burst_c;
                    end
                end
                RBURST, WBURST: begin
                    if (!beat_c) begin
                        state <= IDLE;
                        count <= '0;
                        if (count == CNT_W'(WORDS)) begin
                            burst_done <= 1'b1;
`ifdef RAM_STATS_EN
                            if (!burst_bad) begin
                                if (state == RBURST) begin
                                    if (rd_bursts != 16'hFFFF) rd_bursts <= rd_bursts + 16'd1;
                                end else begin
                                    if (wr_bursts != 16'hFFFF) wr_bursts <= wr_bursts + 16'd1;
                                end
                            end
`endif
                        end
                    end else if (!same_dir_c) begin
                        // Direction switch restarts the burst, tainted by the protocol error.
                        state     <= ram_write ? WBURST : RBURST;
                        count     <= CNT_W'(1);
                        expected  <= ram_addr + ADDR_WIDTH'(1);
                        burst_bad <= 1'b1;
                    end else begin
                        if (count != CNT_W'(WORDS + 1)) begin
                            count <= count + CNT_W'(1);
                        end
                        expected  <= ram_addr + ADDR_WIDTH'(1);
                        burst_bad <= burst_bad || set_proto_c || set_burst_c;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder: clear sweep, burst framing, errors, reset.
module tb_ram_responder;

    localparam int unsigned DW = 10;
    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ram_addr;
    logic          ram_read;
    logic [DW-1:0] ram_data_out;
    logic          ram_write;
    logic [DW-1:0] ram_data_in;
    logic          init_busy;
    logic          burst_done;
    logic          err_proto;
    logic          err_burst;
    logic          err_clear;
`ifdef RAM_STATS_EN
    logic [15:0]   rd_bursts;
    logic [15:0]   wr_bursts;
`endif

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    ram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .ram_addr     (ram_addr),
        .ram_read     (ram_read),
        .ram_data_out (ram_data_out),
        .ram_write    (ram_write),
        .ram_data_in  (ram_data_in),
        .init_busy    (init_busy),
        .burst_done   (burst_done),
        .err_proto    (err_proto),
        .err_burst    (err_burst),
        .err_clear    (err_clear)
`ifdef RAM_STATS_EN
        ,
        .rd_bursts    (rd_bursts),
        .wr_bursts    (wr_bursts)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one beat at the falling edge, return at the next falling edge.
    task automatic beat(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram_read    = rd;
        ram_write   = wr;
        ram_addr    = a;
        ram_data_in = d;
        @(negedge clk);
    endtask

    task automatic idle();
        ram_read  = 1'b0;
        ram_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic clr();
        err_clear = 1'b1;
        idle();
        err_clear = 1'b0;
    endtask

    task automatic wait_init(output int cyc);
        cyc = 0;
        while (init_busy && cyc < 20000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] base);
        for (int i = 0; i < 32; i++) begin
            beat(1'b1, 1'b0, base + AW'(i), '0);
            check("rb_data", ram_data_out, 32'(DW'(base + AW'(i))));
        end
        idle();
        check("rb_done", burst_done, 1);
    endtask

    initial begin
        rst = 1'b1; ram_addr = '0; ram_read = 1'b0; ram_write = 1'b0;
        ram_data_in = '0; err_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", init_busy, 1);
        check("rst_dout", ram_data_out, 0);
        check("rst_eproto", err_proto, 0);
        check("rst_eburst", err_burst, 0);
        check("rst_done", burst_done, 0);

        rst = 1'b0;
        wait_init(n);
        check("busy_cycles", n, 16384);

        beat(1'b1, 1'b0, 14'h1234, '0);
        check("rd_1234", ram_data_out, 0);
        idle();
        clr();
        check("clr_first", err_burst, 0);

        // Write-back then fill of the same line, data = address low bits.
        for (int i = 0; i < 32; i++) begin
            beat(1'b0, 1'b1, AW'(16'h40 + i), DW'(16'h40 + i));
        end
        idle();
        check("wb_done", burst_done, 1);
        read_burst(14'h0040);
        check("rb_eproto", err_proto, 0);
        check("rb_eburst", err_burst, 0);

        beat(1'b1, 1'b0, 14'h0041, '0);
        check("mis_err", err_burst, 1);
        check("mis_data", ram_data_out, 32'h041);
        beat(1'b1, 1'b0, 14'h0042, '0);
        idle();
        clr();
        check("mis_clr", err_burst, 0);

        for (int i = 0; i < 31; i++) beat(1'b1, 1'b0, AW'(16'h60 + i), '0);
        idle();
        check("short_done", burst_done, 0);
        check("short_err", err_burst, 1);
        clr();

        for (int i = 0; i < 32; i++) beat(1'b1, 1'b0, AW'(16'h80 + i), '0);
        check("long_b32", err_burst, 0);
        beat(1'b1, 1'b0, 14'h00A0, '0);
        check("long_b33", err_burst, 1);
        idle();
        check("long_done", burst_done, 0);
        clr();

        beat(1'b0, 1'b1, 14'h0200, 10'h2AA);
        beat(1'b1, 1'b0, 14'h0201, '0);
        check("dir_proto", err_proto, 1);
        idle();
        clr();

        beat(1'b1, 1'b1, 14'h0100, 10'h155);
        check("rw_proto", err_proto, 1);
        idle();
        clr();
        check("rw_clr", err_proto, 0);
        beat(1'b1, 1'b0, 14'h0100, '0);
        check("rw_data", ram_data_out, 32'h155);
        idle();

        // Reset lands on beat 10 of a write burst; err_burst from the lone read is still set.
        for (int i = 0; i < 9; i++) beat(1'b0, 1'b1, AW'(16'h40 + i), 10'h3FF);
        rst = 1'b1;
        beat(1'b0, 1'b1, 14'h0049, 10'h3FF);
        rst = 1'b0;
        check("mid_busy", init_busy, 1);
        check("mid_dout", ram_data_out, 0);
        check("mid_eproto", err_proto, 0);
        check("mid_eburst", err_burst, 0);
        check("mid_done", burst_done, 0);
        idle(); idle(); idle(); idle();
        beat(1'b1, 1'b0, 14'h0045, '0);
        check("clr_rd_proto", err_proto, 1);
        check("clr_rd_data", ram_data_out, 0);
        ram_read = 1'b0;
        wait_init(n);
        check("init_done2", init_busy, 0);
        clr();
        check("clr_after", err_proto, 0);

        beat(1'b0, 1'b1, 14'h0300, 10'h111);
        idle();
        beat(1'b1, 1'b0, 14'h0300, '0);
        check("wr300", ram_data_out, 32'h111);
        idle();
        beat(1'b1, 1'b0, 14'h0045, '0);
        check("rezero", ram_data_out, 0);
        idle();
        clr();

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 32; i++) beat(1'b1, 1'b0, AW'(16'h400 + 32 * b + i), '0);
            idle();
            check("st_done", burst_done, 1);
        end
        check("st_eburst", err_burst, 0);
        check("st_eproto", err_proto, 0);
`ifdef RAM_STATS_EN
        check("rd_bursts", rd_bursts, 3);
        check("wr_bursts", wr_bursts, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Word-addressable backing store answering the cache's RAM-side burst protocol: line fill (read) and line write-back (write).
- Registered reads with fixed one-cycle latency, so the cache captures beat N-1 while presenting beat N.
- Clears itself after reset, tracks burst framing and flags protocol violations through sticky error bits.
- Sits directly below the cache in the memory hierarchy.

Parameters:
- DATA_WIDTH, 10, word width in bits.
- ADDR_WIDTH, 14, word address width; depth is 2**ADDR_WIDTH words.
- WORDS, 32, beats per legal burst (cache line size); power of two.
- OFFSET, $clog2(WORDS), low address bits selecting the word within a line.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- ram_addr  input  ADDR_WIDTH  word address of the current beat.
- ram_read  input  1  read beat request.
- ram_data_out  output  DATA_WIDTH  registered read data.
- ram_write  input  1  write beat request.
- ram_data_in  input  DATA_WIDTH  write data.
- init_busy  output  1  high while the post-reset clear sweep runs.
- burst_done  output  1  one-cycle pulse after a complete WORDS-beat burst.
- err_proto  output  1  sticky: illegal access (busy, read and write together, or direction switch).
- err_burst  output  1  sticky: misaligned start, non-sequential beat or wrong beat count.
- err_clear  input  1  clears both sticky errors.

Behaviour:
- Reset (sampled on posedge clk with rst=1): FSM goes to CLEAR, clear pointer 0, ram_data_out 0, burst_done 0, errors 0, beat counter 0. Reset overrides everything, including mid-burst and mid-clear.
- FSM states: CLEAR, IDLE, RBURST, WBURST.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle; ptr increments; init_busy=1.
  - When the write to address 2**ADDR_WIDTH-1 is done, goes to IDLE.
  - Total: exactly 2**ADDR_WIDTH cycles.
  - Any ram_read or ram_write seen in CLEAR is ignored and sets err_proto.
- Read beat (ram_read=1 at edge):
  - ram_data_out <= mem[ram_addr]; valid the cycle after the request.
  - ram_data_out holds its value until the next read beat.
  - Read of an address being written in the same edge cannot occur (write and read together is an error, see below).
- Write beat (ram_write=1 at edge): mem[ram_addr] <= ram_data_in; ram_data_out unchanged.
- ram_read and ram_write together: write performed, read ignored, err_proto set; treated as a write beat for burst tracking.
- Burst tracking:
  - IDLE to RBURST/WBURST on the first beat.
  - The first beat's address[OFFSET-1:0] must be 0, else err_burst.
  - Record expected = addr+1, modulo 2**ADDR_WIDTH; wrap from all-ones to 0 is legal arithmetic but misaligned, so it is flagged by the alignment rule.
  - Beat counter width $clog2(WORDS)+1.
- In a burst:
  - Each beat must match expected, else err_burst; the beat is still performed and expected resyncs to addr+1.
  - Opposite-direction beat: err_proto, and the burst restarts in the new direction with count=1.
  - A cycle with no request ends the burst: return to IDLE.
  - If count==WORDS at end: burst_done=1 the cycle after the idle cycle is sampled.
  - Otherwise err_burst is set.
  - A beat beyond WORDS sets err_burst immediately.
- Back-to-back bursts need at least one idle cycle, matching cache LOAD→READ behaviour.
- err_clear: clears both errors at the edge; a new error on the same edge wins (stays set).
- Outputs are all registered except init_busy, which is decoded from state.

Optional Feature:
- RAM_STATS_EN defined:
  - Adds outputs rd_bursts and wr_bursts, each 16 bits, counting completed legal bursts per direction.
  - Counters saturate at 16'hFFFF and reset to 0.
  - A burst that set err_burst or err_proto does not count.
- RAM_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then idle → init_busy=1 for exactly 16384 cycles, then 0; read of 0x1234 returns 10'h000.
- Write burst at 0x0040..0x005F with data=addr[9:0], idle, then read burst 0x0040..0x005F → each ram_data_out one cycle after request equals the address low bits; burst_done pulses twice; errors 0.
- Read burst starting at 0x0041 → err_burst=1 after first beat; data still returned. Then err_clear pulse → err_burst=0.
- Read burst of 31 beats then idle → err_burst=1, no burst_done; 33-beat burst → err_burst set on beat 33.
- ram_read and ram_write together at 0x0100 with data 10'h155 → err_proto=1, mem[0x0100]=10'h155 on later read; read during CLEAR → err_proto=1, no data update.
- rst asserted mid write burst at beat 10 → next cycle state CLEAR, all outputs 0; memory rezeroed after the sweep. With RAM_STATS_EN: 3 legal read bursts → rd_bursts=3, wr_bursts=0.
